// File: rtl/uart_cmd_controller_pkg.sv
// ============================================================================
// Module  : uart_cmd_controller_pkg
// Brief   : Shared frame constants and state encodings for the uart command
//           controller and its response serializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_cmd_controller_pkg;

    localparam int CAC_UART_BITLEN   = 8;
    localparam int CAC_UART_ERRORNUM = 4;

    localparam logic [7:0] CAC_CMD_HDR       = 8'hA5;
    localparam logic [7:0] CAC_CMD_WR        = 8'h01;
    localparam logic [7:0] CAC_CMD_RD        = 8'h02;
    localparam logic [7:0] CAC_STAT_OK       = 8'h00;
    localparam logic [7:0] CAC_STAT_BAD_CHK  = 8'h01;
    localparam logic [7:0] CAC_STAT_BAD_CMD  = 8'h02;
    localparam logic [7:0] CAC_STAT_TIMEOUT  = 8'h03;

    typedef enum logic [2:0] {
        S_HUNT = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4,
        S_EXEC = 3'd5,
        S_RESP = 3'd6
    } ctl_state_t;

    typedef enum logic [0:0] {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_cmd_tx_serializer.sv
// ============================================================================
// Module  : uart_cmd_tx_serializer
// Brief   : Emits a response frame HDR STAT [DATA x NB] CHK into the uart TX
//           FIFO under tx_full backpressure and pulses o_done on the last byte.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_tx_serializer
    import uart_cmd_controller_pkg::*;
#(
    parameter int BITLEN     = CAC_UART_BITLEN,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  i_start,
    input  logic [BITLEN-1:0]     i_stat,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_has_data,
    input  logic                  i_tx_full,
    output logic [BITLEN-1:0]     o_tx_data,
    output logic                  o_tx_write,
    output logic                  o_done
);

    localparam int NB    = DATA_WIDTH / BITLEN;
    localparam int IDX_W = $clog2(NB + 3);

    ser_state_t              r_state;
    ser_state_t              w_state_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        r_last;
    logic [BITLEN-1:0]       r_stat;
    logic [BITLEN-1:0]       r_chk;
    logic [BITLEN-1:0]       r_tx_data;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_tx_write;
    logic                    r_done;
    logic                    w_emit;
    logic                    w_is_last;
    logic [BITLEN-1:0]       w_byte;

    assign w_is_last = (r_idx == r_last);

    // Index 0 is always the header so a stale r_last after reset cannot alias it
    always_comb begin
        if (r_idx == '0)
            w_byte = BITLEN'(CAC_CMD_HDR);
        else if (r_idx == IDX_W'(1))
            w_byte = r_stat;
        else if (w_is_last)
            w_byte = r_chk;
        else
            w_byte = r_data[DATA_WIDTH-1 -: BITLEN];
    end

    // Never write on consecutive cycles so tx_full always reflects our last push
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        case (r_state)
            SER_IDLE: begin
                if (i_start) begin
                    w_state_nxt = SER_SEND;
                    w_emit      = !i_tx_full;
                end
            end
            SER_SEND: begin
                if (!r_tx_write && !i_tx_full) begin
                    w_emit = 1'b1;
                    if (w_is_last)
                        w_state_nxt = SER_IDLE;
                end
            end
            default: w_state_nxt = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            r_state <= SER_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_idx      <= '0;
            r_last     <= '0;
            r_stat     <= '0;
            r_chk      <= '0;
            r_data     <= '0;
            r_tx_data  <= '0;
            r_tx_write <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tx_write <= w_emit;
            r_done     <= w_emit && (r_state == SER_SEND) && w_is_last;
            if (w_emit)
                r_tx_data <= w_byte;
            if (r_state == SER_IDLE && i_start) begin
                r_stat <= i_stat;
                r_chk  <= i_stat;
                r_data <= i_data;
                r_last <= i_has_data ? IDX_W'(NB + 2) : IDX_W'(2);
                r_idx  <= w_emit ? IDX_W'(1) : '0;
            end else if (w_emit) begin
                r_idx <= w_is_last ? '0 : r_idx + IDX_W'(1);
                if (r_idx >= IDX_W'(2) && !w_is_last) begin
                    r_chk  <= r_chk ^ r_data[DATA_WIDTH-1 -: BITLEN];
                    r_data <= {r_data[DATA_WIDTH-BITLEN-1:0], {BITLEN{1'b0}}};
                end
            end
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_write = r_tx_write;
    assign o_done     = r_done;

endmodule

`default_nettype wire

// File: rtl/uart_cmd_controller.sv
// ============================================================================
// Module  : uart_cmd_controller
// Brief   : Parses framed register read/write commands from the uart RX FIFO,
//           drives the register bus and returns a framed status response.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_controller
    import uart_cmd_controller_pkg::*;
#(
    parameter int BITLEN      = CAC_UART_BITLEN,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int ERR_WIDTH   = $clog2(CAC_UART_ERRORNUM),
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [BITLEN-1:0]     rx_data,
    input  logic                  rx_empty,
    output logic                  rx_read,
    input  logic [ERR_WIDTH-1:0]  rx_error,
    output logic [BITLEN-1:0]     tx_data,
    output logic                  tx_write,
    input  logic                  tx_full,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_ack,
    output logic                  busy,
    output logic [7:0]            frame_err_cnt
);

    localparam int NB     = DATA_WIDTH / BITLEN;
    localparam int BCNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

    ctl_state_t              r_state;
    ctl_state_t              w_state_nxt;
    logic                    r_rx_read;
    logic                    r_cap;
    logic                    r_is_wr;
    logic                    r_bad_cmd;
    logic [BCNT_W-1:0]       r_bcnt;
    logic [BITLEN-1:0]       r_chk;
    logic [ADDR_WIDTH-1:0]   r_addr_sh;
    logic [DATA_WIDTH-1:0]   r_data_sh;
    logic [ADDR_WIDTH-1:0]   r_reg_addr;
    logic [DATA_WIDTH-1:0]   r_reg_wdata;
    logic                    r_reg_wr;
    logic                    r_reg_rd;
    logic [7:0]              r_err_cnt;
    logic [TMO_W-1:0]        r_tmo;

    logic                    w_byte_vld;
    logic                    w_in_parse;
    logic                    w_want_byte;
    logic                    w_tmo_exp;
    logic                    w_parse_abort;
    logic                    w_err_inc;
    logic                    w_ser_start;
    logic [BITLEN-1:0]       w_ser_stat;
    logic                    w_ser_has_data;
    logic                    w_ser_done;

    assign w_byte_vld    = r_cap;
    assign w_in_parse    = (r_state == S_CMD) || (r_state == S_ADDR) ||
                           (r_state == S_DATA) || (r_state == S_CHK);
    // One read in flight at a time: fetch, then capture, then the next fetch
    assign w_want_byte   = ((r_state == S_HUNT) || w_in_parse) && !rx_empty &&
                           !r_rx_read && !r_cap;
    assign w_tmo_exp     = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
    assign w_parse_abort = (rx_error != '0) || (w_tmo_exp && !w_byte_vld);

    always_comb begin
        w_state_nxt    = r_state;
        w_ser_start    = 1'b0;
        w_ser_stat     = BITLEN'(CAC_STAT_OK);
        w_ser_has_data = 1'b0;
        w_err_inc      = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (w_byte_vld && rx_data == BITLEN'(CAC_CMD_HDR))
                    w_state_nxt = S_CMD;
            end
            S_CMD, S_ADDR, S_DATA, S_CHK: begin
                if (w_parse_abort) begin
                    w_state_nxt = S_HUNT;
                    w_err_inc   = 1'b1;
                end else if (w_byte_vld) begin
                    if (r_state == S_CMD) begin
                        w_state_nxt = S_ADDR;
                    end else if (r_state == S_ADDR) begin
                        w_state_nxt = r_is_wr ? S_DATA : S_CHK;
                    end else if (r_state == S_DATA) begin
                        if (r_bcnt == BCNT_W'(NB - 1))
                            w_state_nxt = S_CHK;
                    end else if (r_bad_cmd) begin
                        w_state_nxt = S_RESP;
                        w_ser_start = 1'b1;
                        w_ser_stat  = BITLEN'(CAC_STAT_BAD_CMD);
                        w_err_inc   = 1'b1;
                    end else if (rx_data != r_chk) begin
                        w_state_nxt = S_RESP;
                        w_ser_start = 1'b1;
                        w_ser_stat  = BITLEN'(CAC_STAT_BAD_CHK);
                        w_err_inc   = 1'b1;
                    end else begin
                        w_state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                // reg_ack is checked before the timeout so it wins a tie
                if (r_is_wr) begin
                    w_state_nxt = S_RESP;
                    w_ser_start = 1'b1;
                end else if (reg_ack) begin
                    w_state_nxt    = S_RESP;
                    w_ser_start    = 1'b1;
                    w_ser_has_data = 1'b1;
                end else if (w_tmo_exp) begin
                    w_state_nxt = S_RESP;
                    w_ser_start = 1'b1;
                    w_ser_stat  = BITLEN'(CAC_STAT_TIMEOUT);
                    w_err_inc   = 1'b1;
                end
            end
            S_RESP: begin
                if (w_ser_done)
                    w_state_nxt = S_HUNT;
            end
            default: w_state_nxt = S_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            r_state <= S_HUNT;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_rx_read   <= 1'b0;
            r_cap       <= 1'b0;
            r_is_wr     <= 1'b0;
            r_bad_cmd   <= 1'b0;
            r_bcnt      <= '0;
            r_chk       <= '0;
            r_addr_sh   <= '0;
            r_data_sh   <= '0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_err_cnt   <= '0;
            r_tmo       <= '0;
        end else begin
            r_rx_read <= w_want_byte;
            r_cap     <= r_rx_read;
            r_reg_wr  <= 1'b0;
            if (w_byte_vld) begin
                case (r_state)
                    S_CMD: begin
                        r_is_wr   <= (rx_data == BITLEN'(CAC_CMD_WR));
                        r_bad_cmd <= (rx_data != BITLEN'(CAC_CMD_WR)) &&
                                     (rx_data != BITLEN'(CAC_CMD_RD));
                        r_chk     <= rx_data;
                        r_bcnt    <= '0;
                    end
                    S_ADDR: begin
                        r_addr_sh <= ADDR_WIDTH'(rx_data);
                        r_chk     <= r_chk ^ rx_data;
                    end
                    S_DATA: begin
                        r_data_sh <= {r_data_sh[DATA_WIDTH-BITLEN-1:0], rx_data};
                        r_chk     <= r_chk ^ rx_data;
                        r_bcnt    <= r_bcnt + BCNT_W'(1);
                    end
                    default: ;
                endcase
            end
            // Bus address/data only change when a validated command executes
            if (r_state == S_CHK && w_state_nxt == S_EXEC) begin
                r_reg_addr <= r_addr_sh;
                if (r_is_wr) begin
                    r_reg_wdata <= r_data_sh;
                    r_reg_wr    <= 1'b1;
                end else begin
                    r_reg_rd <= 1'b1;
                end
            end
            if (r_state == S_EXEC && w_ser_start)
                r_reg_rd <= 1'b0;
            if (w_err_inc && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
            if (w_state_nxt != r_state || w_byte_vld || !(w_in_parse || r_state == S_EXEC))
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    uart_cmd_tx_serializer #(
        .BITLEN     (BITLEN),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx_ser (
        .clk        (clk),
        .rstb       (rstb),
        .i_start    (w_ser_start),
        .i_stat     (w_ser_stat),
        .i_data     (reg_rdata),
        .i_has_data (w_ser_has_data),
        .i_tx_full  (tx_full),
        .o_tx_data  (tx_data),
        .o_tx_write (tx_write),
        .o_done     (w_ser_done)
    );

    assign rx_read       = r_rx_read;
    assign reg_addr      = r_reg_addr;
    assign reg_wdata     = r_reg_wdata;
    assign reg_wr        = r_reg_wr;
    assign reg_rd        = r_reg_rd;
    assign busy          = (r_state != S_HUNT);
    assign frame_err_cnt = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_controller.sv
// ============================================================================
// Module  : tb_uart_cmd_controller
// Brief   : Scoreboard bench: models the uart FIFOs and a register slave,
//           queues expected TX bytes and register writes, compares on output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_controller;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_empty = 1'b1;
    logic        rx_read;
    logic [1:0]  rx_error = '0;
    logic [7:0]  tx_data;
    logic        tx_write;
    logic        tx_full = 1'b0;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_rdata = '0;
    logic        reg_ack = 1'b0;
    logic        busy;
    logic [7:0]  frame_err_cnt;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_tx[$];
    logic [39:0] exp_wr[$];
    logic [7:0]  exp_rd_addr;
    logic [31:0] rd_val = '0;
    bit          ack_en = 1'b1;
    int          rd_cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          wr_cyc = 0;
    bit          lat_armed = 1'b0;
    int          tx_cnt = 0;
    int          exp_err = 0;

    uart_cmd_controller #(
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rstb          (rstb),
        .rx_data       (rx_data),
        .rx_empty      (rx_empty),
        .rx_read       (rx_read),
        .rx_error      (rx_error),
        .tx_data       (tx_data),
        .tx_write      (tx_write),
        .tx_full       (tx_full),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_wr        (reg_wr),
        .reg_rd        (reg_rd),
        .reg_rdata     (reg_rdata),
        .reg_ack       (reg_ack),
        .busy          (busy),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RX FIFO model: a read pulse pops the head onto rx_data for later capture
    always @(negedge clk) begin
        if (rstb && rx_read && rx_q.size() != 0)
            rx_data = rx_q.pop_front();
        rx_empty = (rx_q.size() == 0);
    end

    always @(negedge clk) begin
        if (rstb && tx_write) begin
            tx_cnt++;
            if (lat_armed) begin
                check("wr_to_tx_latency", cyc - wr_cyc, 1);
                lat_armed = 1'b0;
            end
            if (exp_tx.size() == 0)
                check("tx_unexpected", {24'd0, tx_data}, 32'h100);
            else
                check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
        end
    end

    always @(negedge clk) begin
        logic [39:0] e;
        if (rstb) begin
            if (reg_wr) begin
                wr_cyc    = cyc;
                lat_armed = 1'b1;
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", {24'd0, reg_addr}, 32'h1FF);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", {24'd0, reg_addr}, {24'd0, e[39:32]});
                    check("wr_data", reg_wdata, e[31:0]);
                end
            end
            if (reg_ack) begin
                reg_ack = 1'b0;
                check("rd_drop_after_ack", {31'd0, reg_rd}, 32'd0);
            end else if (reg_rd && ack_en) begin
                rd_cyc++;
                if (rd_cyc == 3) begin
                    check("rd_addr", {24'd0, reg_addr}, {24'd0, exp_rd_addr});
                    reg_ack   = 1'b1;
                    reg_rdata = rd_val;
                end
            end else if (!reg_rd) begin
                rd_cyc = 0;
            end
        end
    end

    task automatic push_rx(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) rx_q.push_back(v[8*i +: 8]);
    endtask

    task automatic expect_tx(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_tx.push_back(v[8*i +: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while ((exp_tx.size() != 0 || busy || rx_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_complete"}, {31'd0, n < 3000}, 32'd1);
        check({tag, "_err_cnt"}, {24'd0, frame_err_cnt}, exp_err);
    endtask

    initial begin
        int n;
        int base;
        repeat (3) @(negedge clk);
        check("rst_rx_read", {31'd0, rx_read}, 0);
        check("rst_tx_write", {31'd0, tx_write}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_reg_wr_rd", {30'd0, reg_wr, reg_rd}, 0);
        check("rst_reg_addr", {24'd0, reg_addr}, 0);
        check("rst_reg_wdata", reg_wdata, 0);
        check("rst_busy_cnt", {23'd0, busy, frame_err_cnt}, 0);
        rstb = 1'b1;

        // Write
        exp_wr.push_back({8'h10, 32'hDEADBEEF});
        expect_tx(64'hA5_00_00, 3);
        push_rx(64'hA5_01_10_DE_AD_BE_EF_33, 8);
        wait_idle("write");
        check("wr_addr_hold", {24'd0, reg_addr}, 32'h10);
        check("wr_data_hold", reg_wdata, 32'hDEADBEEF);

        // Read
        rd_val = 32'h12345678;
        exp_rd_addr = 8'h20;
        expect_tx(64'hA5_00_12_34_56_78_08, 7);
        push_rx(64'hA5_02_20_22, 4);
        wait_idle("read");

        // Bad checksum
        exp_err++;
        expect_tx(64'hA5_01_01, 3);
        push_rx(64'hA5_01_10_DE_AD_BE_EF_34, 8);
        wait_idle("bad_chk");

        // Hunt garbage then bad command
        exp_err++;
        expect_tx(64'hA5_02_02, 3);
        push_rx(64'h00_FF_A5_07_10_17, 6);
        wait_idle("bad_cmd");

        // Inter-byte timeout: silent abort
        exp_err++;
        push_rx(64'hA5_01_10, 3);
        wait_idle("byte_timeout");

        // Register ack timeout
        exp_err++;
        ack_en = 1'b0;
        exp_rd_addr = 8'h20;
        expect_tx(64'hA5_03_03, 3);
        push_rx(64'hA5_02_20_22, 4);
        wait_idle("ack_timeout");
        ack_en = 1'b1;

        // Line error mid-frame: silent abort
        exp_err++;
        push_rx(64'hA5_01, 2);
        repeat (12) @(negedge clk);
        rx_error = 2'b01;
        @(negedge clk);
        rx_error = 2'b00;
        wait_idle("rx_error");

        // Backpressure mid-response
        rd_val = 32'hCAFEF00D;
        exp_rd_addr = 8'h30;
        expect_tx(64'hA5_00_CA_FE_F0_0D_C9, 7);
        base = tx_cnt;
        push_rx(64'hA5_02_30_32, 4);
        n = 0;
        while (tx_cnt == base && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("bp_first_byte_seen", {31'd0, n < 500}, 32'd1);
        @(posedge clk);
        #1 tx_full = 1'b1;
        repeat (2) @(negedge clk);
        base = tx_cnt;
        repeat (48) @(negedge clk);
        check("bp_no_write_while_full", tx_cnt - base, 0);
        tx_full = 1'b0;
        wait_idle("backpressure");

        // Reset mid-frame, then a clean frame
        push_rx(64'hA5_01_10_DE, 4);
        repeat (8) @(negedge clk);
        rstb = 1'b0;
        rx_q.delete();
        rd_cyc = 0;
        lat_armed = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_cnt", {24'd0, frame_err_cnt}, 0);
        check("midrst_outs", {28'd0, rx_read, tx_write, reg_wr, reg_rd}, 0);
        rstb = 1'b1;
        exp_err = 0;
        exp_wr.push_back({8'h10, 32'hDEADBEEF});
        expect_tx(64'hA5_00_00, 3);
        push_rx(64'hA5_01_10_DE_AD_BE_EF_33, 8);
        wait_idle("post_reset");

        check("exp_wr_drained", exp_wr.size(), 0);
        check("exp_tx_drained", exp_tx.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
